vga_stream_out: RTL and testbench

Display-side consumer of the pixel stream produced by `Main` (`o_RGB` / `o_RGB_valid`). It buffers incoming 24-bit pixels in a FIFO and generates VGA 1280x1024@60 timing from the same 108 MHz clock: 1688 x 1066 = 1,799,408 cycles per frame. It drives registered R/G/B, sync and blank outputs for the board DAC. It also reports FIFO underflow and overflow so the renderer's pixel rate can be checked in simulation and on hardware.

---
 rtl/vga_stream_out.sv | 198 +++++++++++++++++++
 tb/tb_vga_stream_out.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_stream_out.sv
// Pixel FIFO plus VGA timing generator: buffers a 24-bit pixel stream and replays it
// under HS/VS/BLANK timing from the same clock, flagging underflow and overflow.
module vga_stream_out #(
    parameter int unsigned H_ACTIVE   = 1280,
    parameter int unsigned H_FP       = 48,
    parameter int unsigned H_SYNC     = 112,
    parameter int unsigned H_BP       = 248,
    parameter int unsigned V_ACTIVE   = 1024,
    parameter int unsigned V_FP       = 1,
    parameter int unsigned V_SYNC     = 3,
    parameter int unsigned V_BP       = 38,
    parameter logic        SYNC_POL   = 1'b1,
    parameter int unsigned FIFO_DEPTH = 2048,
    parameter int unsigned PREFILL    = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [23:0] i_RGB,
    input  logic        i_RGB_valid,
    output logic        o_ready,
    output logic [7:0]  o_VGA_R,
    output logic [7:0]  o_VGA_G,
    output logic [7:0]  o_VGA_B,
    output logic        o_VGA_HS,
    output logic        o_VGA_VS,
    output logic        o_VGA_BLANK_N,
    output logic        o_frame_start,
    output logic        o_underflow,
    output logic        o_overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG_I = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END_I = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG_I = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END_I = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned H_LAST_I     = H_TOTAL - 1;
    localparam int unsigned V_LAST_I     = V_TOTAL - 1;

    localparam logic [10:0] H_ACT_END  = H_ACTIVE[10:0];
    localparam logic [10:0] H_SYNC_BEG = H_SYNC_BEG_I[10:0];
    localparam logic [10:0] H_SYNC_END = H_SYNC_END_I[10:0];
    localparam logic [10:0] H_LAST     = H_LAST_I[10:0];
    localparam logic [10:0] V_ACT_END  = V_ACTIVE[10:0];
    localparam logic [10:0] V_SYNC_BEG = V_SYNC_BEG_I[10:0];
    localparam logic [10:0] V_SYNC_END = V_SYNC_END_I[10:0];
    localparam logic [10:0] V_LAST     = V_LAST_I[10:0];

    localparam logic [AW:0] PREFILL_LVL = PREFILL[AW:0];
    localparam logic [AW:0] PTR_ONE     = {{AW{1'b0}}, 1'b1};

    localparam logic StIdle = 1'b0;
    localparam logic StRun  = 1'b1;

    // Storage and pointers
    logic [23:0] mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0] level;
    logic        full, empty, full_next;

    // Timing state
    logic        state_q, state_d;
    logic [10:0] h_q, h_d;
    logic [10:0] v_q, v_d;

    // Registered outputs
    logic [7:0]  r_q, r_d;
    logic [7:0]  g_q, g_d;
    logic [7:0]  b_q, b_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d;
    logic        overflow_q, overflow_d;
    logic        ready_q, ready_d;

    logic        running, active, pop, push;
    logic [23:0] rd_data;

    always_comb begin
        level   = wr_ptr_q - rd_ptr_q;
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        running = (state_q == StRun);
        active  = running && (h_q < H_ACT_END) && (v_q < V_ACT_END);
        pop     = active && !empty;
        // A full FIFO still takes a push when a pop frees a slot on the same cycle.
        push    = i_RGB_valid && (!full || pop);
        rd_data = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_comb begin
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        full_next = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                    (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        ready_d   = !full_next;
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        unique case (state_q)
            StIdle: begin
                h_d = 11'd0;
                v_d = 11'd0;
                if (level >= PREFILL_LVL) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (h_q == H_LAST) begin
                    h_d = 11'd0;
                    v_d = (v_q == V_LAST) ? 11'd0 : v_q + 11'd1;
                end else begin
                    h_d = h_q + 11'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the current counters so pixel and syncs share one cycle of latency.
    always_comb begin
        r_d           = pop ? rd_data[23:16] : 8'h00;
        g_d           = pop ? rd_data[15:8]  : 8'h00;
        b_d           = pop ? rd_data[7:0]   : 8'h00;
        blank_n_d     = active;
        hs_d          = (running && (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END)) ?
                        SYNC_POL : ~SYNC_POL;
        vs_d          = (running && (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END)) ?
                        SYNC_POL : ~SYNC_POL;
        frame_start_d = running && (h_q == 11'd0) && (v_q == 11'd0);
        underflow_d   = underflow_q || (active && empty);
        overflow_d    = overflow_q || (i_RGB_valid && !push);
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_RGB;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            state_q       <= StIdle;
            h_q           <= 11'd0;
            v_q           <= 11'd0;
            r_q           <= 8'h00;
            g_q           <= 8'h00;
            b_q           <= 8'h00;
            hs_q          <= ~SYNC_POL;
            vs_q          <= ~SYNC_POL;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            overflow_q    <= 1'b0;
            ready_q       <= 1'b1;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            r_q           <= r_d;
            g_q           <= g_d;
            b_q           <= b_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            overflow_q    <= overflow_d;
            ready_q       <= ready_d;
        end
    end

    assign o_ready       = ready_q;
    assign o_VGA_R       = r_q;
    assign o_VGA_G       = g_q;
    assign o_VGA_B       = b_q;
    assign o_VGA_HS      = hs_q;
    assign o_VGA_VS      = vs_q;
    assign o_VGA_BLANK_N = blank_n_q;
    assign o_frame_start = frame_start_q;
    assign o_underflow   = underflow_q;
    assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_vga_stream_out.sv
// Bench for vga_stream_out with a reduced 16x8 raster: timing checkpoint table plus a
// pixel scoreboard, with prefill, underflow, mid-frame reset and overflow sequences.
module tb_vga_stream_out;

    localparam int HA = 8, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 4, VF = 1, VSW = 2, VB = 1;
    localparam int DEPTH = 16, PRE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] rgb_in = 24'h0;
    logic        valid = 1'b0;
    logic        ready, hs, vs, blank_n, fs, uf, ovf;
    logic [7:0]  r, g, b;

    always #5 clk = ~clk;

    vga_stream_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .SYNC_POL(1'b1), .FIFO_DEPTH(DEPTH), .PREFILL(PRE)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_RGB(rgb_in), .i_RGB_valid(valid),
        .o_ready(ready), .o_VGA_R(r), .o_VGA_G(g), .o_VGA_B(b),
        .o_VGA_HS(hs), .o_VGA_VS(vs), .o_VGA_BLANK_N(blank_n),
        .o_frame_start(fs), .o_underflow(uf), .o_overflow(ovf)
    );

    typedef struct {
        int   c;
        logic blank;
        logic hs;
        logic vs;
        logic fs;
        logic uf;
    } tvec_t;

    tvec_t       tbl[$];
    logic [23:0] exp_q[$];
    int          n_cmp = 0, n_fail = 0, cyc = 0, n_acc = 0, t_store = -1, feed_idx = 0, t0 = 0;
    logic        feed_en = 1'b0, drv_ok = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endfunction

    task automatic drive_next();
        if (feed_en && ready === 1'b1) begin
            valid  = 1'b1;
            rgb_in = (feed_idx < PRE) ? 24'h112233 : 24'(feed_idx);
            feed_idx++;
            drv_ok = 1'b1;
        end else begin
            valid  = 1'b0;
            drv_ok = 1'b0;
        end
    endtask

    // One clock: outputs checked #1 after the edge, before that edge's push joins the queue.
    task automatic step();
        logic        pushed, ok, was_rst;
        logic [23:0] pdata;
        pushed  = valid;
        ok      = drv_ok;
        pdata   = rgb_in;
        was_rst = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (was_rst) begin
            exp_q.delete();
        end else if (blank_n === 1'b1) begin
            if (exp_q.size() > 0) chk("pixel", 32'({r, g, b}), 32'(exp_q.pop_front()));
            else                  chk("underflow_black", 32'({r, g, b}), 32'h0);
        end else begin
            chk("blank_black", 32'({r, g, b}), 32'h0);
        end
        if (pushed && ok && !was_rst) begin
            exp_q.push_back(pdata);
            n_acc++;
            if (n_acc == PRE && t_store < 0) t_store = cyc;
        end
        drive_next();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        chk({tag, "_rgb"}, 32'({r, g, b}), 32'h0);
        chk({tag, "_blank_n"}, 32'(blank_n), 32'd0);
        chk({tag, "_hs"}, 32'(hs), 32'd0);
        chk({tag, "_vs"}, 32'(vs), 32'd0);
        chk({tag, "_frame_start"}, 32'(fs), 32'd0);
        chk({tag, "_underflow"}, 32'(uf), 32'd0);
        chk({tag, "_overflow"}, 32'(ovf), 32'd0);
    endtask

    initial begin
        // Checkpoints: cycle offset from first pixel -> blank_n, hs, vs, frame_start, underflow
        tbl.push_back('{0,   1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{1,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{7,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{8,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{9,   1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{10,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{12,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{13,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{15,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{16,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{55,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{56,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{64,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{79,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{80,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{90,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{111, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
        tbl.push_back('{112, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{127, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{128, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
        tbl.push_back('{138, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
        tbl.push_back('{256, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{266, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{336, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
        tbl.push_back('{383, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        tbl.push_back('{384, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1});
        tbl.push_back('{394, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});

        // Power-up reset and prefill
        rst = 1'b1;
        step();
        step();
        chk_reset("por");
        rst     = 1'b0;
        feed_en = 1'b1;
        drive_next();
        while (t_store < 0 && cyc < 200) step();
        chk("prefill_reached", 32'(t_store >= 0), 32'd1);
        if (t_store < 0) begin
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
            $finish;
        end
        chk("ready_low_when_full", 32'(ready), 32'd0);
        step();
        chk("blank_before_start", 32'(blank_n), 32'd0);
        step();
        t0 = cyc;
        chk("first_pixel", 32'({r, g, b}), 32'h112233);

        // Timing checkpoints; feed paused for offsets 150..299 to force underflow
        foreach (tbl[i]) begin
            while (cyc < t0 + tbl[i].c) begin
                feed_en = !((cyc - t0 >= 150) && (cyc - t0 < 300));
                step();
            end
            chk($sformatf("blank_n@%0d", tbl[i].c), 32'(blank_n), 32'(tbl[i].blank));
            chk($sformatf("hs@%0d", tbl[i].c), 32'(hs), 32'(tbl[i].hs));
            chk($sformatf("vs@%0d", tbl[i].c), 32'(vs), 32'(tbl[i].vs));
            chk($sformatf("frame_start@%0d", tbl[i].c), 32'(fs), 32'(tbl[i].fs));
            chk($sformatf("underflow@%0d", tbl[i].c), 32'(uf), 32'(tbl[i].uf));
        end
        chk("no_overflow_when_gated", 32'(ovf), 32'd0);

        // Reset in the middle of a frame (line 2, pixel 4 of frame 4)
        feed_en = 1'b1;
        while (cyc < t0 + 547) step();
        feed_en = 1'b0;
        valid   = 1'b0;
        drv_ok  = 1'b0;
        rst     = 1'b1;
        step();
        chk_reset("mid_frame");
        rst = 1'b0;
        step();
        step();
        chk("idle_after_reset_blank", 32'(blank_n), 32'd0);
        chk("idle_after_reset_ready", 32'(ready), 32'd1);

        // Overflow: 17 back-to-back pushes into a 16-deep FIFO before timing starts
        n_acc   = 0;
        t_store = -1;
        for (int k = 0; k < 17; k++) begin
            valid  = 1'b1;
            rgb_in = 24'hA00000 | 24'(k);
            drv_ok = (k < DEPTH);
            step();
            if (k == 15) begin
                chk("ready_after_full", 32'(ready), 32'd0);
                chk("no_overflow_yet", 32'(ovf), 32'd0);
            end
        end
        chk("overflow_set", 32'(ovf), 32'd1);
        chk("blank_pre_restart", 32'(blank_n), 32'd0);
        step();
        chk("restart_blank", 32'(blank_n), 32'd1);
        chk("restart_frame_start", 32'(fs), 32'd1);
        chk("restart_pixel", 32'({r, g, b}), 32'hA00000);
        repeat (140) step();
        chk("fifo_drained", 32'(exp_q.size()), 32'd0);
        chk("overflow_sticky", 32'(ovf), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
